// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: widths, opcode codes, FSM states
// and the helper that says which opcodes produce a register result.
package operand_fetch_pkg;

  localparam int OF_DATA_WIDTH = 16;
  localparam int OF_NUM_REGS   = 16;
  localparam int OF_REG_ADDR_W = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_e;

  // CMP only drives the ALU flag, and unknown opcodes must leave the scoreboard alone
  function automatic logic writes_rd(input logic [3:0] op);
    logic result;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_ADDI: result = 1'b1;
      default:                         result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous write port.
// Register 0 always reads zero and ignores writes.
module operand_fetch_reg_file
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = OF_DATA_WIDTH,
  parameter int NUM_REGS   = OF_NUM_REGS,
  parameter int REG_ADDR_W = OF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage ahead of the ALU: buffers one instruction, stalls on RAW/WAW via a scoreboard,
// then presents registered operands. Define OPERAND_BYPASS_EN to forward a matching writeback in CHECK.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = OF_DATA_WIDTH,
  parameter int NUM_REGS   = OF_NUM_REGS,
  parameter int REG_ADDR_W = OF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic [DATA_WIDTH-1:0] in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_opcode,
  output logic [DATA_WIDTH-1:0] out_operand_a,
  output logic [DATA_WIDTH-1:0] out_operand_b,
  output logic [REG_ADDR_W-1:0] out_rd,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  fetch_state_e state_q, state_d;

  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q, rs_q, rt_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic [DATA_WIDTH-1:0] operand_a_d, operand_b_d;
  logic                  src_a_hazard, src_b_hazard, dst_hazard, hazard;
  logic                  accept, issue_load, retire;

  operand_fetch_reg_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr_a(rs_q),
    .raddr_b(rt_q),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b)
  );

  assign in_ready   = rst_n && (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_ISSUE);
  assign accept     = in_valid && in_ready;
  assign issue_load = (state_q == ST_CHECK) && !hazard;
  assign retire     = out_valid && out_ready;

  // Hazard detection and operand selection for the held instruction
  always_comb begin
    src_a_hazard = (rs_q != '0) && pending_q[rs_q];
    src_b_hazard = (op_q != OP_ADDI) && (rt_q != '0) && pending_q[rt_q];
    dst_hazard   = writes_rd(op_q) && (rd_q != '0) && pending_q[rd_q];
    operand_a_d  = rdata_a;
    operand_b_d  = (op_q == OP_ADDI) ? imm_q : rdata_b;
`ifdef OPERAND_BYPASS_EN
    if (src_a_hazard && wb_en && (wb_rd == rs_q)) begin
      src_a_hazard = 1'b0;
      operand_a_d  = wb_data;
    end
    if (src_b_hazard && wb_en && (wb_rd == rt_q)) begin
      src_b_hazard = 1'b0;
      operand_b_d  = wb_data;
    end
`else
`endif
    hazard = src_a_hazard || src_b_hazard || dst_hazard;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_CHECK;
      ST_CHECK: if (!hazard) state_d = ST_ISSUE;
      ST_ISSUE: if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Set on retire is applied after the writeback clear so it wins on the same index
  always_comb begin
    pending_d = pending_q;
    if (wb_en && (wb_rd != '0)) pending_d[wb_rd] = 1'b0;
    if (retire && writes_rd(out_opcode) && (out_rd != '0)) pending_d[out_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q          <= '0;
      rd_q          <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      imm_q         <= '0;
      out_opcode    <= '0;
      out_operand_a <= '0;
      out_operand_b <= '0;
      out_rd        <= '0;
    end else begin
      if (accept) begin
        op_q  <= in_opcode;
        rd_q  <= in_rd;
        rs_q  <= in_rs;
        rt_q  <= in_rt;
        imm_q <= in_imm;
      end
      if (issue_load) begin
        out_opcode    <= op_q;
        out_operand_a <= operand_a_d;
        out_operand_b <= operand_b_d;
        out_rd        <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch: reset, issue latency, stall on RAW,
// scoreboard set/clear, r0 handling and reset during ISSUE.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_rd, in_rs, in_rt;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [15:0] out_operand_a, out_operand_b;
  logic [3:0]  out_rd;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;

  int checks   = 0;
  int failures = 0;

  operand_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_rd        (in_rd),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .in_imm       (in_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_operand_a(out_operand_a),
    .out_operand_b(out_operand_b),
    .out_rd       (out_rd),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clk = ~clk;

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic writeBack(input logic [3:0] rd, input logic [15:0] data);
    wb_en   = 1'b1;
    wb_rd   = rd;
    wb_data = data;
    waitCycle();
    wb_en   = 1'b0;
  endtask

  // Present one instruction for the accept edge, then drop in_valid
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                               input logic [3:0] rt, input logic [15:0] imm);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
    in_imm    = imm;
    waitCycle();
    in_valid  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    waitCycle();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    wb_rd = '0; wb_data = '0;
    #1;

    // Reset held two cycles
    waitCycle();
    waitCycle();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", in_ready, 1);
    checkOutput("rel_pending", dut.pending_q, 16'h0000);

    // ADD r3 = r1 + r2 with r1=7, r2=5
    writeBack(4'd1, 16'd7);
    writeBack(4'd2, 16'd5);
    applyStimulus(OP_ADD, 4'd3, 4'd1, 4'd2, 16'd0);
    checkOutput("add_n1_valid", out_valid, 0);
    checkOutput("add_n1_in_ready", in_ready, 0);
    waitCycle();
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_opcode", out_opcode, OP_ADD);
    checkOutput("add_a", out_operand_a, 7);
    checkOutput("add_b", out_operand_b, 5);
    checkOutput("add_rd", out_rd, 3);
    handshake();
    checkOutput("add_pending3", dut.pending_q, 16'h0008);
    checkOutput("add_in_ready", in_ready, 1);
    writeBack(4'd3, 16'd12);
    writeBack(4'd1, 16'd10);
    checkOutput("wb_clear_pending", dut.pending_q, 16'h0000);

    // ADDI r4 = r1 + 15 with downstream back-pressure
    applyStimulus(OP_ADDI, 4'd4, 4'd1, 4'd2, 16'd15);
    waitCycle();
    for (int i = 0; i < 3; i++) begin
      checkOutput("addi_hold_valid", out_valid, 1);
      checkOutput("addi_hold_a", out_operand_a, 10);
      checkOutput("addi_hold_b", out_operand_b, 15);
      waitCycle();
    end
    checkOutput("addi_opcode", out_opcode, OP_ADDI);
    checkOutput("addi_rd", out_rd, 4);
    handshake();
    checkOutput("addi_pending4", dut.pending_q, 16'h0010);

    // SUB r5 = r4 - r2 stalls until r4 is written back
    applyStimulus(OP_SUB, 4'd5, 4'd4, 4'd2, 16'd0);
    waitCycle();
    checkOutput("sub_stall1", out_valid, 0);
    waitCycle();
    checkOutput("sub_stall2", out_valid, 0);
    writeBack(4'd4, 16'd25);
`ifdef OPERAND_BYPASS_EN
    checkOutput("sub_bypass_valid", out_valid, 1);
`else
    checkOutput("sub_wb_cycle_valid", out_valid, 0);
    waitCycle();
    checkOutput("sub_valid", out_valid, 1);
`endif
    checkOutput("sub_a", out_operand_a, 25);
    checkOutput("sub_b", out_operand_b, 5);
    checkOutput("sub_opcode", out_opcode, OP_SUB);
    handshake();
    checkOutput("sub_pending5", dut.pending_q, 16'h0020);
    writeBack(4'd5, 16'd20);

    // CMP sets nothing; MUL with r0; writes to r0 ignored
    writeBack(4'd2, 16'd2);
    writeBack(4'd8, 16'd8);
    applyStimulus(OP_CMP, 4'd6, 4'd2, 4'd8, 16'd0);
    waitCycle();
    checkOutput("cmp_a", out_operand_a, 2);
    checkOutput("cmp_b", out_operand_b, 8);
    handshake();
    checkOutput("cmp_no_pending", dut.pending_q, 16'h0000);
    applyStimulus(OP_MUL, 4'd7, 4'd1, 4'd0, 16'd0);
    waitCycle();
    checkOutput("mul_a", out_operand_a, 10);
    checkOutput("mul_b", out_operand_b, 0);
    handshake();
    checkOutput("mul_pending7", dut.pending_q, 16'h0080);
    writeBack(4'd7, 16'd70);
    writeBack(4'd0, 16'd99);
    applyStimulus(OP_ADD, 4'd0, 4'd0, 4'd1, 16'd0);
    waitCycle();
    checkOutput("r0_reads_zero", out_operand_a, 0);
    checkOutput("r0_b", out_operand_b, 10);
    handshake();
    checkOutput("rd0_no_pending", dut.pending_q, 16'h0000);

    // Reset while in ISSUE with r3 pending, writeback in the same cycle
    applyStimulus(OP_ADD, 4'd3, 4'd1, 4'd2, 16'd0);
    waitCycle();
    handshake();
    checkOutput("pre_rst_pending3", dut.pending_q, 16'h0008);
    applyStimulus(OP_ADD, 4'd9, 4'd1, 4'd2, 16'd0);
    waitCycle();
    checkOutput("pre_rst_issue", out_valid, 1);
    rst_n   = 1'b0;
    wb_en   = 1'b1;
    wb_rd   = 4'd1;
    wb_data = 16'd77;
    waitCycle();
    wb_en   = 1'b0;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_pending", dut.pending_q, 16'h0000);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_out_rd", out_rd, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    applyStimulus(OP_ADD, 4'd0, 4'd1, 4'd8, 16'd0);
    waitCycle();
    checkOutput("post_rst_valid", out_valid, 1);
    checkOutput("post_rst_r1", out_operand_a, 0);
    checkOutput("post_rst_r8", out_operand_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
